// File: rtl/brick_grid_memory.sv
// brick_grid_memory
//   Brick store for the playfield. Holds a ROWS x COLS grid of brick health
//   values, serves a free-running registered read port (health plus the pixel
//   position of the addressed brick), applies hits as a two-cycle
//   read-modify-write decrement, fills the grid on request and keeps a count of
//   live bricks for level-clear detection.
//
// Ports
//   clk            rising-edge system clock
//   reset          asynchronous, active-high; clears grid, counters and outputs
//   init_start     request a fill of every brick with INIT_HEALTH
//   busy           high while the fill is running (exactly N cycles)
//   rd_col/rd_row  read address
//   rd_health      health at the read address, one cycle later (0 if out of range)
//   rd_x/rd_y      pixel position of the read address, one cycle later
//   hit_valid      hit request, accepted when hit_valid & hit_ready
//   hit_col/row    hit target
//   hit_ready      combinational: idle and no fill being requested
//   hit_done       one-cycle pulse carrying the hit result
//   hit_destroyed  with hit_done: the brick went from 1 to 0
//   hit_miss       with hit_done: target out of range or already 0
//   alive_count    number of bricks with health > 0
//   all_clear      registered: grid has been loaded and no brick is alive
module brick_grid_memory #(
  parameter int COLS        = 8,
  parameter int ROWS        = 4,
  parameter int HEALTH_W    = 2,
  parameter int INIT_HEALTH = 3,
  parameter int BRICK_W     = 40,
  parameter int BRICK_H     = 15,
  parameter int X_ORIGIN    = 0,
  parameter int Y_ORIGIN    = 0,
  parameter int COORD_W     = 10,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int N  = COLS * ROWS,
  localparam int AW = $clog2(N + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                init_start,
  output logic                busy,
  input  logic [CW-1:0]       rd_col,
  input  logic [RW-1:0]       rd_row,
  output logic [HEALTH_W-1:0] rd_health,
  output logic [COORD_W-1:0]  rd_x,
  output logic [COORD_W-1:0]  rd_y,
  input  logic                hit_valid,
  input  logic [CW-1:0]       hit_col,
  input  logic [RW-1:0]       hit_row,
  output logic                hit_ready,
  output logic                hit_done,
  output logic                hit_destroyed,
  output logic                hit_miss,
  output logic [AW-1:0]       alive_count,
  output logic                all_clear
);

  // Width of a flat grid index (row*COLS + col).
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    HIT  = 2'd2
  } state_t;

  state_t               state_reg;
  logic [IW-1:0]        ptr_reg;
  logic [CW-1:0]        tgt_col_reg;
  logic [RW-1:0]        tgt_row_reg;
  logic                 busy_reg;
  logic                 loaded_reg;
  logic [AW-1:0]        alive_reg;
  logic                 all_clear_reg;
  logic                 hit_done_reg;
  logic                 hit_destroyed_reg;
  logic                 hit_miss_reg;
  logic [HEALTH_W-1:0]  rd_health_reg;
  logic [COORD_W-1:0]   rd_x_reg;
  logic [COORD_W-1:0]   rd_y_reg;

  logic [HEALTH_W-1:0]  mem [N];

  // Hit target decode (uses the latched target while in HIT).
  logic                 tgt_in_range;
  logic [IW-1:0]        tgt_idx;
  logic [HEALTH_W-1:0]  tgt_health;
  logic                 hit_we;
  logic                 init_we;

  // Read address decode.
  logic                 rd_in_range;
  logic [IW-1:0]        rd_idx;

  always_comb begin
    tgt_in_range = (int'(tgt_row_reg) < ROWS) && (int'(tgt_col_reg) < COLS);
    tgt_idx      = IW'(int'(tgt_row_reg) * COLS + int'(tgt_col_reg));
    // Out-of-range targets read as dead so they fall into the miss path.
    tgt_health   = tgt_in_range ? mem[tgt_idx] : '0;
    hit_we       = (state_reg == HIT) && tgt_in_range && (tgt_health != '0);
    init_we      = (state_reg == INIT);
    rd_in_range  = (int'(rd_row) < ROWS) && (int'(rd_col) < COLS);
    rd_idx       = IW'(int'(rd_row) * COLS + int'(rd_col));
  end

  assign hit_ready = (state_reg == IDLE) && !init_start;

  // Grid storage. Reset clears every entry so an aborted fill or hit leaves
  // no stale bricks behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        mem[i] <= '0;
      end
    end else if (init_we) begin
      mem[ptr_reg] <= HEALTH_W'(INIT_HEALTH);
    end else if (hit_we) begin
      mem[tgt_idx] <= tgt_health - HEALTH_W'(1);
    end
  end

  // Control FSM with registered outputs and the registered read port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg         <= IDLE;
      ptr_reg           <= '0;
      tgt_col_reg       <= '0;
      tgt_row_reg       <= '0;
      busy_reg          <= 1'b0;
      loaded_reg        <= 1'b0;
      alive_reg         <= '0;
      all_clear_reg     <= 1'b0;
      hit_done_reg      <= 1'b0;
      hit_destroyed_reg <= 1'b0;
      hit_miss_reg      <= 1'b0;
      rd_health_reg     <= '0;
      rd_x_reg          <= '0;
      rd_y_reg          <= '0;
    end else begin
      hit_done_reg      <= 1'b0;
      hit_destroyed_reg <= 1'b0;
      hit_miss_reg      <= 1'b0;
      all_clear_reg     <= loaded_reg && (alive_reg == '0);

      // Reads see the array before any write on this same edge.
      rd_health_reg <= rd_in_range ? mem[rd_idx] : '0;
      rd_x_reg      <= rd_in_range ? COORD_W'(X_ORIGIN + int'(rd_col) * BRICK_W) : '0;
      rd_y_reg      <= rd_in_range ? COORD_W'(Y_ORIGIN + int'(rd_row) * BRICK_H) : '0;

      case (state_reg)
        IDLE: begin
          // A fill request takes priority over a simultaneous hit.
          if (init_start) begin
            state_reg <= INIT;
            busy_reg  <= 1'b1;
            ptr_reg   <= '0;
          end else if (hit_valid) begin
            tgt_col_reg <= hit_col;
            tgt_row_reg <= hit_row;
            state_reg   <= HIT;
          end
        end
        INIT: begin
          if (ptr_reg == IW'(N - 1)) begin
            alive_reg  <= AW'(N);
            loaded_reg <= 1'b1;
            busy_reg   <= 1'b0;
            state_reg  <= IDLE;
          end else begin
            ptr_reg <= ptr_reg + IW'(1);
          end
        end
        HIT: begin
          hit_done_reg <= 1'b1;
          if (tgt_health == '0) begin
            hit_miss_reg <= 1'b1;
          end else if (tgt_health == HEALTH_W'(1)) begin
            hit_destroyed_reg <= 1'b1;
            alive_reg         <= alive_reg - AW'(1);
          end
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy          = busy_reg;
  assign alive_count   = alive_reg;
  assign all_clear     = all_clear_reg;
  assign hit_done      = hit_done_reg;
  assign hit_destroyed = hit_destroyed_reg;
  assign hit_miss      = hit_miss_reg;
  assign rd_health     = rd_health_reg;
  assign rd_x          = rd_x_reg;
  assign rd_y          = rd_y_reg;

endmodule

// File: tb/tb_brick_grid_memory.sv
module tb_brick_grid_memory;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       init_start, o_init_start;
  logic [2:0] rd_col, hit_col;
  logic [1:0] rd_row, hit_row;
  logic       hit_valid, o_hit_valid;

  // Default 8x4 grid
  logic       busy, hit_ready, hit_done, hit_destroyed, hit_miss, all_clear;
  logic [1:0] rd_health;
  logic [9:0] rd_x, rd_y;
  logic [5:0] alive_count;

  // 6x3 grid with offsets, used for out-of-range coverage
  logic       o_busy, o_hit_ready, o_hit_done, o_hit_destroyed, o_hit_miss, o_all_clear;
  logic [1:0] o_rd_health;
  logic [9:0] o_rd_x, o_rd_y;
  logic [4:0] o_alive_count;

  int n_checks = 0;
  int n_fail   = 0;

  brick_grid_memory dut (
    .clk(clk), .reset(reset), .init_start(init_start), .busy(busy),
    .rd_col(rd_col), .rd_row(rd_row), .rd_health(rd_health), .rd_x(rd_x), .rd_y(rd_y),
    .hit_valid(hit_valid), .hit_col(hit_col), .hit_row(hit_row), .hit_ready(hit_ready),
    .hit_done(hit_done), .hit_destroyed(hit_destroyed), .hit_miss(hit_miss),
    .alive_count(alive_count), .all_clear(all_clear)
  );

  brick_grid_memory #(
    .COLS(6), .ROWS(3), .INIT_HEALTH(2), .BRICK_W(10), .BRICK_H(5),
    .X_ORIGIN(3), .Y_ORIGIN(7)
  ) dut_odd (
    .clk(clk), .reset(reset), .init_start(o_init_start), .busy(o_busy),
    .rd_col(rd_col), .rd_row(rd_row), .rd_health(o_rd_health), .rd_x(o_rd_x), .rd_y(o_rd_y),
    .hit_valid(o_hit_valid), .hit_col(hit_col), .hit_row(hit_row), .hit_ready(o_hit_ready),
    .hit_done(o_hit_done), .hit_destroyed(o_hit_destroyed), .hit_miss(o_hit_miss),
    .alive_count(o_alive_count), .all_clear(o_all_clear)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int r, input int c);
    rd_row = 2'(r);
    rd_col = 3'(c);
    tick();
  endtask

  // Pulse init on one instance and count the cycles busy stays high.
  task automatic init_pulse(input bit sel, output int cycles);
    if (sel) o_init_start = 1'b1; else init_start = 1'b1;
    tick();
    o_init_start = 1'b0;
    init_start   = 1'b0;
    cycles = 0;
    while ((sel ? o_busy : busy) && cycles < 200) begin
      cycles++;
      tick();
    end
  endtask

  // Issue one hit; res = {hit_done, hit_destroyed, hit_miss} at the done cycle.
  task automatic do_hit(input bit sel, input int r, input int c, output logic [2:0] res);
    int n;
    hit_row = 2'(r);
    hit_col = 3'(c);
    if (sel) o_hit_valid = 1'b1; else hit_valid = 1'b1;
    n = 0;
    while (!(sel ? o_hit_ready : hit_ready) && n < 100) begin
      tick();
      n++;
    end
    check("hit_accept_wait", (n < 100) ? 1 : 0, 1);
    tick();
    hit_valid   = 1'b0;
    o_hit_valid = 1'b0;
    n = 0;
    while (!(sel ? o_hit_done : hit_done) && n < 10) begin
      tick();
      n++;
    end
    res = sel ? {o_hit_done, o_hit_destroyed, o_hit_miss}
              : {hit_done, hit_destroyed, hit_miss};
  endtask

  initial begin
    int         cyc, bad, dn, dcount;
    logic [2:0] res;

    reset = 1'b1;
    init_start = 1'b0; o_init_start = 1'b0;
    hit_valid = 1'b0;  o_hit_valid = 1'b0;
    hit_col = '0; hit_row = '0;
    rd_col = 3'd5; rd_row = 2'd2;
    repeat (3) tick();

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_alive", alive_count, 0);
    check("rst_all_clear", all_clear, 0);
    check("rst_hit_done", hit_done, 0);
    check("rst_rd_x", rd_x, 0);
    check("rst_rd_health", rd_health, 0);
    reset = 1'b0;
    tick();

    // 1: fill
    init_pulse(0, cyc);
    check("init_busy_cycles", cyc, 32);
    check("init_alive", alive_count, 32);
    check("init_all_clear", all_clear, 0);
    bad = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 8; c++) begin
        rd(r, c);
        if (rd_health != 2'd3) bad++;
      end
    check("init_bad_entries", bad, 0);
    rd(2, 5);
    check("rd_x_col5", rd_x, 200);
    check("rd_y_row2", rd_y, 30);
    rd(3, 7);
    check("rd_x_col7", rd_x, 280);
    check("rd_y_row3", rd_y, 45);
    init_pulse(1, cyc);
    check("odd_busy_cycles", cyc, 18);
    check("odd_alive", o_alive_count, 18);

    // 2: repeated hits on (1,2)
    rd_row = 2'd1; rd_col = 3'd2;
    do_hit(0, 1, 2, res);
    check("hit1_res", res, 3'b100);
    check("hit1_rd_old", rd_health, 3);
    tick();
    check("hit1_health", rd_health, 2);
    check("hit_done_pulse", hit_done, 0);
    do_hit(0, 1, 2, res);
    check("hit2_res", res, 3'b100);
    tick();
    check("hit2_health", rd_health, 1);
    do_hit(0, 1, 2, res);
    check("hit3_res", res, 3'b110);
    check("hit3_alive", alive_count, 31);
    tick();
    check("hit3_health", rd_health, 0);
    do_hit(0, 1, 2, res);
    check("hit4_res", res, 3'b101);
    tick();
    check("hit4_health", rd_health, 0);
    check("hit4_alive", alive_count, 31);

    // 3: out-of-range on the 6x3 grid
    rd(0, 7);
    check("oor_rd_health", o_rd_health, 0);
    check("oor_rd_x", o_rd_x, 0);
    check("oor_rd_y", o_rd_y, 0);
    rd(2, 5);
    check("odd_rd_health", o_rd_health, 2);
    check("odd_rd_x", o_rd_x, 53);
    check("odd_rd_y", o_rd_y, 17);
    do_hit(1, 0, 7, res);
    check("oor_col_res", res, 3'b101);
    do_hit(1, 3, 0, res);
    check("oor_row_res", res, 3'b101);
    check("oor_alive", o_alive_count, 18);
    do_hit(1, 2, 5, res);
    check("odd_hit_res", res, 3'b100);
    rd(2, 5);
    check("odd_hit_health", o_rd_health, 1);

    // 4: init and hit requested together
    hit_row = 2'd0; hit_col = 3'd0;
    hit_valid = 1'b1; init_start = 1'b1;
    #1;
    check("ready_with_init", hit_ready, 0);
    tick();
    init_start = 1'b0;
    cyc = 0; dn = 0;
    while (busy && cyc < 200) begin
      if (hit_done || hit_ready) dn++;
      cyc++;
      tick();
    end
    check("reinit_busy_cycles", cyc, 32);
    check("stall_events", dn, 0);
    check("reinit_alive", alive_count, 32);
    check("ready_after_init", hit_ready, 1);
    tick();
    hit_valid = 1'b0;
    tick();
    check("stalled_hit_done", {hit_done, hit_destroyed, hit_miss}, 3'b100);
    rd(0, 0);
    check("stalled_hit_health", rd_health, 2);

    // 5: clear the whole grid
    dcount = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 8; c++)
        for (int k = 0; k < 3; k++) begin
          do_hit(0, r, c, res);
          if (res[1]) dcount++;
        end
    check("destroyed_total", dcount, 32);
    tick();
    tick();
    check("clear_alive", alive_count, 0);
    check("all_clear_set", all_clear, 1);
    init_pulse(0, cyc);
    check("refill_alive", alive_count, 32);
    tick();
    check("all_clear_drop", all_clear, 0);

    // 6: reset in the middle of a fill
    rd(1, 2);
    check("pre_rst_health", rd_health, 3);
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    repeat (10) tick();
    check("mid_init_busy", busy, 1);
    reset = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_alive", alive_count, 0);
    check("abort_rd_health", rd_health, 0);
    check("abort_rd_x", rd_x, 0);
    check("abort_hit_done", hit_done, 0);
    repeat (2) tick();
    reset = 1'b0;
    tick();
    bad = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 8; c++) begin
        rd(r, c);
        if (rd_health != 2'd0) bad++;
      end
    check("abort_bad_entries", bad, 0);
    check("abort_all_clear", all_clear, 0);
    check("abort_busy_after", busy, 0);
    check("abort_alive_after", alive_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
